// File: rtl/mem_stage_pkg.sv
// Shared load/store encodings and the memory-stage state type.
package mem_stage_pkg;

    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    localparam logic [6:0] INST_TYPE_L = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S = 7'b0100011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_t;

    function automatic logic is_mem_opcode(input logic [6:0] opcode);
        return (opcode == INST_TYPE_L) || (opcode == INST_TYPE_S);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for stores, extraction/extension for loads,
// and the legality/alignment check for both.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        legal,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        legal      = 1'b0;
        wstrb      = '0;
        wdata_lane = wdata;
        if (we) begin
            case (func3)
                INST_SB: begin
                    legal      = 1'b1;
                    wstrb      = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                INST_SH: begin
                    legal      = ~addr_lo[0];
                    wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
                INST_SW: begin
                    legal = (addr_lo == 2'b00);
                    wstrb = 4'b1111;
                end
                default: ;
            endcase
        end else begin
            case (func3)
                INST_LB, INST_LBU: legal = 1'b1;
                INST_LH, INST_LHU: legal = ~addr_lo[0];
                INST_LW:           legal = (addr_lo == 2'b00);
                default: ;
            endcase
        end
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            INST_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            INST_LBU: load_data = {24'b0, byte_sel};
            INST_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            INST_LHU: load_data = {16'b0, half_sel};
            default:  load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers EX writeback and runs single-outstanding
// loads/stores on the data bus, stalling ctrl while an access is in flight.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_wen_i,
    input  logic        mem_en_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_func3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wen_o,
    output logic        hold_flag_o,
    output logic        misalign_o
);

    mem_state_t  state;
    logic        idle;
    logic [4:0]  cap_rd;
    logic [2:0]  cap_func3;
    logic [1:0]  cap_addr_lo;
    logic [2:0]  al_func3;
    logic [1:0]  al_addr_lo;
    logic        legal;
    logic [3:0]  wstrb;
    logic [31:0] wdata_lane;
    logic [31:0] load_data;

    assign idle = (state == MEM_IDLE);

    // One aligner serves both phases: live inputs while IDLE (legality and
    // steering), captured func3/offset afterwards (load extraction in WAIT).
    assign al_func3   = idle ? mem_func3_i     : cap_func3;
    assign al_addr_lo = idle ? mem_addr_i[1:0] : cap_addr_lo;

    mem_align u_align (
        .we         (mem_we_i),
        .func3      (al_func3),
        .addr_lo    (al_addr_lo),
        .wdata      (mem_wdata_i),
        .rdata      (bus_rdata_i),
        .legal      (legal),
        .wstrb      (wstrb),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    assign hold_flag_o = ~idle | (mem_en_i & legal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MEM_IDLE;
            cap_rd      <= '0;
            cap_func3   <= '0;
            cap_addr_lo <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
            rd_addr_o   <= '0;
            rd_data_o   <= '0;
            rd_wen_o    <= 1'b0;
            misalign_o  <= 1'b0;
        end else begin
            rd_wen_o   <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (!mem_en_i) begin
                        rd_addr_o <= rd_addr_i;
                        rd_data_o <= rd_data_i;
                        rd_wen_o  <= rd_wen_i;
                    end else if (legal) begin
                        cap_rd      <= rd_addr_i;
                        cap_func3   <= mem_func3_i;
                        cap_addr_lo <= mem_addr_i[1:0];
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_wdata_o <= wdata_lane;
                        bus_wstrb_o <= wstrb;
                        bus_req_o   <= 1'b1;
                        state       <= MEM_REQ;
                    end else begin
                        misalign_o <= 1'b1;
                    end
                end
                MEM_REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        state     <= bus_we_o ? MEM_IDLE : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (bus_rvalid_i) begin
                        rd_addr_o <= cap_rd;
                        rd_data_o <= load_data;
                        rd_wen_o  <= 1'b1;
                        state     <= MEM_IDLE;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule
